cg_result_writeback: RTL

CG_RESULT_WRITEBACK -- requirements
Module: cg_result_writeback

---
 rtl/cg_pkg.sv | 19 +
 rtl/cg_result_writeback_if.sv | 23 ++
 rtl/cg_wb_fifo.sv | 43 ++++
 rtl/cg_result_writeback.sv | 110 +++++++++++
 4 files changed

// File: rtl/cg_pkg.sv
// rtl/cg_pkg.sv - shared FSM encoding and pass-geometry helpers for cg_result_writeback
package cg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } wb_state_e;

    function automatic int total_beats(input int clusters, input int equations, input int units);
        return (clusters * equations + units - 1) / units;
    endfunction

    // Populated lanes in the final beat; 0 means the final beat is completely full.
    function automatic int last_beat_lanes(input int clusters, input int equations, input int units);
        return (clusters * equations) % units;
    endfunction

endpackage

// File: rtl/cg_result_writeback_if.sv
// rtl/cg_result_writeback_if.sv - ALU result beat stream in, result-memory write port out
interface cg_result_writeback_if #(
    parameter int data_width = 512,
    parameter int addr_width = 20
);
    logic                  in_valid;
    logic [data_width-1:0] in_data;
    logic                  in_ready;
    logic                  mem_ready;
    logic                  mem_we;
    logic [addr_width-1:0] mem_write_address;
    logic [data_width-1:0] mem_data;

    modport slave (
        input  in_valid, in_data, mem_ready,
        output in_ready, mem_we, mem_write_address, mem_data
    );

    modport master (
        output in_valid, in_data, mem_ready,
        input  in_ready, mem_we, mem_write_address, mem_data
    );
endinterface

// File: rtl/cg_wb_fifo.sv
// rtl/cg_wb_fifo.sv - order-preserving beat buffer; full/empty derive only from registered occupancy
module cg_wb_fifo #(
    parameter int width = 512,
    parameter int depth = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             push,
    input  logic [width-1:0] push_data,
    input  logic             pop,
    output logic [width-1:0] head,
    output logic             full,
    output logic             empty
);
    localparam int PW = $clog2(depth);

    logic [width-1:0] store [depth];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [PW:0]      count;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) store[wr_ptr] <= push_data;
    end

    assign head  = store[rd_ptr];
    assign full  = (count == (PW+1)'(depth));
    assign empty = (count == '0);
endmodule

// File: rtl/cg_result_writeback.sv
// rtl/cg_result_writeback.sv - buffers ALU result beats and writes one vector pass to result memory
// Optional: CG_WB_LAST_BEAT_MASK_EN zeroes the unpopulated lanes of the final beat.
module cg_result_writeback
    import cg_pkg::*;
#(
    parameter int element_width                   = 64,
    parameter int no_of_units                     = 8,
    parameter int number_of_clusters              = 40,
    parameter int number_of_equations_per_cluster = 19,
    parameter int memories_address_width          = 20,
    parameter int fifo_depth                      = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    cg_result_writeback_if.slave         wb,
    output logic [31:0]                  written_count,
    output logic                         done
);
    localparam int DW          = no_of_units * element_width;
    localparam int TOTAL_BEATS = total_beats(number_of_clusters, number_of_equations_per_cluster, no_of_units);
    localparam int LAST_LANES  = last_beat_lanes(number_of_clusters, number_of_equations_per_cluster, no_of_units);
    localparam logic [31:0] TOTAL_W = 32'(TOTAL_BEATS);
    localparam logic [memories_address_width-1:0] LAST_ADDR = memories_address_width'(TOTAL_BEATS - 1);

    localparam logic [1:0] IDLE = ST_IDLE;
    localparam logic [1:0] RUN  = ST_RUN;
    localparam logic [1:0] DONE = ST_DONE;

    logic [1:0]                        state;
    logic [31:0]                       accepted_count;
    logic [memories_address_width-1:0] wr_addr;
    logic                              fifo_full;
    logic                              fifo_empty;
    logic [DW-1:0]                     fifo_head;
    logic [DW-1:0]                     lane_mask;
    logic                              open_pass;
    logic                              push;
    logic                              pop;

    assign open_pass    = (state == IDLE) && start;
    assign wb.in_ready  = (state == RUN) && !fifo_full && (accepted_count < TOTAL_W);
    assign push         = wb.in_valid && wb.in_ready;
    assign pop          = (state == RUN) && !fifo_empty && wb.mem_ready;
    assign wb.mem_we    = pop;
    assign wb.mem_write_address = wr_addr;
    assign done         = (state == DONE);

    cg_wb_fifo #(
        .width (DW),
        .depth (fifo_depth)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .clear     (open_pass),
        .push      (push),
        .push_data (wb.in_data),
        .pop       (pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            accepted_count <= '0;
            wr_addr        <= '0;
            written_count  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state          <= RUN;
                        accepted_count <= '0;
                        wr_addr        <= '0;
                        written_count  <= '0;
                    end
                end
                RUN: begin
                    if (push) accepted_count <= accepted_count + 32'd1;
                    if (pop) begin
                        written_count <= written_count + 32'd1;
                        // Address parks on the last beat so it never wraps inside a pass.
                        if (wr_addr == LAST_ADDR) state   <= DONE;
                        else                      wr_addr <= wr_addr + 1'b1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef CG_WB_LAST_BEAT_MASK_EN
    always_comb begin
        lane_mask = '1;
        if (LAST_LANES != 0 && wr_addr == LAST_ADDR) begin
            for (int i = 0; i < no_of_units; i++) begin
                if (i >= LAST_LANES) lane_mask[i*element_width +: element_width] = '0;
            end
        end
    end
`else
    assign lane_mask = '1;
`endif

    // Storage is not reset, so present zero whenever nothing is buffered.
    assign wb.mem_data = fifo_empty ? '0 : (fifo_head & lane_mask);
endmodule
